// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Turns a framed byte stream into the load-port writes of the pipelined MIPS
// core. A frame is:
//
//   CMD_LOAD, base address, entry count N (0 means 2^ADDR_W), then N entries.
//   Each entry is 4 instruction bytes followed by 4 data bytes, big-endian.
//
// Each entry ends in a one-cycle writeEnable strobe (WRITE), followed by one
// low cycle (GAP). The core writes on the rising edge of writeEnable, so every
// strobe needs a fresh low-to-high transition. CMD_RUN outside a frame raises
// `run` so the core's clock can be released.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous, active-high reset
//   in_valid / in_data  byte stream; a byte moves when in_valid && in_ready
//   in_ready            low only in WRITE and GAP
//   instruction         assembled instruction word (registered)
//   instructionAddress  instruction memory index (registered)
//   data                assembled data word (registered)
//   dataAddress         data memory index, always equal to instructionAddress
//   writeEnable         one-cycle write strobe to the core
//   run                 core may execute
//   busy                a frame is in progress (any state but IDLE)
//   error               sticky protocol-violation flag, cleared only by rst
//   words_loaded        entries written since the last CMD_LOAD (saturating)
// -----------------------------------------------------------------------------
module program_loader #(
   parameter int          ADDR_W   = 7,
   parameter logic [7:0]  CMD_LOAD = 8'hA5,
   parameter logic [7:0]  CMD_RUN  = 8'h5A
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [31:0]       instruction,
   output logic [ADDR_W-1:0] instructionAddress,
   output logic [31:0]       data,
   output logic [ADDR_W-1:0] dataAddress,
   output logic              writeEnable,
   output logic              run,
   output logic              busy,
   output logic              error,
   output logic [7:0]        words_loaded
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      COUNT,
      INSTR,
      DATA,
      WRITE,
      GAP
   } state_t;

   // A count byte of 0 stands for the full memory depth, so the remaining
   // counter needs one bit more than the address.
   localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

   state_t            state;
   logic [1:0]        byte_idx;    // byte position within the current word
   logic [31:0]       instr_sr;    // instruction shift register
   logic [31:0]       data_sr;     // data shift register
   logic [ADDR_W-1:0] addr_cur;    // address of the entry being assembled
   logic [ADDR_W:0]   remaining;   // entries still to be written in this frame

   logic take;
   assign take = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         in_ready           <= 1'b1;
         busy               <= 1'b0;
         writeEnable        <= 1'b0;
         run                <= 1'b0;
         error              <= 1'b0;
         instruction        <= '0;
         data               <= '0;
         instructionAddress <= '0;
         dataAddress        <= '0;
         words_loaded       <= '0;
         byte_idx           <= '0;
         instr_sr           <= '0;
         data_sr            <= '0;
         addr_cur           <= '0;
         remaining          <= '0;
      end else begin
         // The strobe is raised only on the edge that enters WRITE, so it
         // falls again on the following edge.
         writeEnable <= 1'b0;

         case (state)
            IDLE: begin
               if (take) begin
                  if (in_data == CMD_LOAD) begin
                     run          <= 1'b0;
                     words_loaded <= '0;
                     busy         <= 1'b1;
                     state        <= ADDR;
                  end else if (in_data == CMD_RUN) begin
                     run <= 1'b1;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end

            ADDR: begin
               if (take) begin
                  if (in_data[7]) begin
                     // Out-of-range base: abort the whole frame.
                     error <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     addr_cur <= in_data[ADDR_W-1:0];
                     state    <= COUNT;
                  end
               end
            end

            COUNT: begin
               if (take) begin
                  if (in_data == 8'd0)
                     remaining <= FULL_COUNT;
                  else
                     remaining <= in_data[ADDR_W:0];
                  byte_idx <= '0;
                  state    <= INSTR;
               end
            end

            INSTR: begin
               if (take) begin
                  instr_sr <= {instr_sr[23:0], in_data};
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3)
                     state <= DATA;
               end
            end

            DATA: begin
               if (take) begin
                  data_sr  <= {data_sr[23:0], in_data};
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     // Last payload byte: publish the entry directly. The
                     // final data byte is merged in here, not from data_sr.
                     instruction        <= instr_sr;
                     data               <= {data_sr[23:0], in_data};
                     instructionAddress <= addr_cur;
                     dataAddress        <= addr_cur;
                     addr_cur           <= addr_cur + 1'b1;   // wraps at 2^ADDR_W
                     remaining          <= remaining - 1'b1;
                     if (words_loaded != 8'hFF)
                        words_loaded <= words_loaded + 8'd1;
                     writeEnable        <= 1'b1;
                     in_ready           <= 1'b0;
                     state              <= WRITE;
                  end
               end
            end

            WRITE: begin
               state <= GAP;
            end

            GAP: begin
               in_ready <= 1'b1;
               if (remaining != '0) begin
                  state <= INSTR;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: begin
               in_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader. A negedge monitor records every
// writeEnable strobe (address, instruction, data). It also counts strobe-shape
// violations: strobes wider than one cycle, ready while writing or in the gap,
// and address mismatches. The main sequence compares against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [31:0] instruction;
   logic [6:0]  instructionAddress;
   logic [31:0] data;
   logic [6:0]  dataAddress;
   logic        writeEnable;
   logic        run;
   logic        busy;
   logic        error;
   logic [7:0]  words_loaded;

   int checks = 0;
   int errors = 0;

   program_loader dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_data            (in_data),
      .in_ready           (in_ready),
      .instruction        (instruction),
      .instructionAddress (instructionAddress),
      .data               (data),
      .dataAddress        (dataAddress),
      .writeEnable        (writeEnable),
      .run                (run),
      .busy               (busy),
      .error              (error),
      .words_loaded       (words_loaded)
   );

   always #5 clk = ~clk;

   // ---------------- write monitor ----------------
   int          we_cnt = 0;
   int          viol   = 0;
   logic        prev_we = 1'b0;
   logic [6:0]  rec_addr [256];
   logic [31:0] rec_ins  [256];
   logic [31:0] rec_dat  [256];

   always @(negedge clk) begin
      if (writeEnable) begin
         rec_addr[we_cnt % 256] <= instructionAddress;
         rec_ins[we_cnt % 256]  <= instruction;
         rec_dat[we_cnt % 256]  <= data;
         we_cnt <= we_cnt + 1;
      end
      viol <= viol
            + int'(writeEnable && (prev_we || in_ready || (dataAddress !== instructionAddress)))
            + int'(!writeEnable && prev_we && in_ready);
      prev_we <= writeEnable;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte, hold it until accepted; returns 1 time unit after the
   // accepting edge.
   task automatic send_byte(input logic [7:0] b, input int idle = 0);
      int n = 0;
      repeat (idle) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready)
         check("ready_timeout", {31'd0, in_ready}, 32'd1);
      else
         @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_entry(input logic [31:0] ins, input logic [31:0] dat, input bit rnd = 0);
      for (int k = 3; k >= 0; k--)
         send_byte(ins[k*8 +: 8], rnd ? int'($urandom_range(0, 1)) : 0);
      for (int k = 3; k >= 0; k--)
         send_byte(dat[k*8 +: 8], rnd ? int'($urandom_range(0, 1)) : 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, {31'd0, in_ready},    32'd1);
      check({tag, "_we"},    {31'd0, writeEnable}, 32'd0);
      check({tag, "_run"},   {31'd0, run},         32'd0);
      check({tag, "_busy"},  {31'd0, busy},        32'd0);
      check({tag, "_err"},   {31'd0, error},       32'd0);
      check({tag, "_ins"},   instruction,          32'd0);
      check({tag, "_dat"},   data,                 32'd0);
      check({tag, "_iaddr"}, {25'd0, instructionAddress}, 32'd0);
      check({tag, "_daddr"}, {25'd0, dataAddress},        32'd0);
      check({tag, "_words"}, {24'd0, words_loaded},       32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int          b;
      logic [31:0] ins, dat;

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset_values("reset");

      // Single entry at address 0
      b = we_cnt;
      send_byte(8'hA5);
      check("single_busy", {31'd0, busy}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h01);
      send_entry(32'h20112020, 32'h00000007);
      check("single_we_latency", {31'd0, writeEnable}, 32'd1);
      check("single_ready_low",  {31'd0, in_ready},    32'd0);
      check("single_ins",   instruction, 32'h20112020);
      check("single_dat",   data,        32'h00000007);
      wait_idle();
      check("single_pulses", we_cnt - b, 32'd1);
      check("single_addr",  {25'd0, instructionAddress}, 32'd0);
      check("single_daddr", {25'd0, dataAddress},        32'd0);
      check("single_words", {24'd0, words_loaded},       32'd1);
      check("single_viol",  viol, 32'd0);

      // Three entries from 126: addresses wrap 126, 127, 0
      b = we_cnt;
      send_byte(8'hA5); send_byte(8'h7E); send_byte(8'h03);
      send_entry(32'h11111111, 32'h00000001);
      send_entry(32'h22222222, 32'h00000002);
      send_entry(32'h33333333, 32'h00000003);
      wait_idle();
      check("wrap_pulses", we_cnt - b, 32'd3);
      check("wrap_a0", {25'd0, rec_addr[(b + 0) % 256]}, 32'd126);
      check("wrap_a1", {25'd0, rec_addr[(b + 1) % 256]}, 32'd127);
      check("wrap_a2", {25'd0, rec_addr[(b + 2) % 256]}, 32'd0);
      check("wrap_i1", rec_ins[(b + 1) % 256], 32'h22222222);
      check("wrap_d2", rec_dat[(b + 2) % 256], 32'h00000003);
      check("wrap_words", {24'd0, words_loaded}, 32'd3);
      check("wrap_viol", viol, 32'd0);

      // Count byte 0 means 128 entries; random valid gaps; command values
      // inside the payload are plain data
      b = we_cnt;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      for (int i = 0; i < 128; i++) begin
         ins = {8'hC0, i[7:0], 8'h5A, 8'hA5};
         dat = {i[7:0], 8'hA5, 8'(255 - i), 8'h33};
         send_entry(ins, dat, 1);
      end
      wait_idle();
      check("full_pulses", we_cnt - b, 32'd128);
      for (int i = 0; i < 128; i++) begin
         check("full_addr", {25'd0, rec_addr[(b + i) % 256]}, 32'(i));
         check("full_ins", rec_ins[(b + i) % 256], {8'hC0, i[7:0], 8'h5A, 8'hA5});
         check("full_dat", rec_dat[(b + i) % 256], {i[7:0], 8'hA5, 8'(255 - i), 8'h33});
      end
      check("full_words", {24'd0, words_loaded}, 32'd128);
      check("full_viol", viol, 32'd0);

      // Run, then reload
      send_byte(8'h5A);
      check("run_set", {31'd0, run}, 32'd1);
      check("run_not_busy", {31'd0, busy}, 32'd0);
      send_byte(8'hA5);
      check("reload_run_clr", {31'd0, run}, 32'd0);
      check("reload_words_clr", {24'd0, words_loaded}, 32'd0);
      b = we_cnt;
      send_byte(8'h40); send_byte(8'h01);
      send_entry(32'hA55A5AA5, 32'h0000005A);
      wait_idle();
      check("reload_pulses", we_cnt - b, 32'd1);
      check("reload_addr", {25'd0, instructionAddress}, 32'h40);
      check("reload_ins", instruction, 32'hA55A5AA5);
      check("reload_err_clean", {31'd0, error}, 32'd0);

      // Protocol errors
      b = we_cnt;
      send_byte(8'h33);
      check("err_idle_byte", {31'd0, error}, 32'd1);
      send_byte(8'hA5);
      send_byte(8'h80);
      check("err_addr_bit7", {31'd0, error}, 32'd1);
      check("err_abort_idle", {31'd0, busy}, 32'd0);
      check("err_abort_ready", {31'd0, in_ready}, 32'd1);
      repeat (3) @(negedge clk);
      check("err_no_writes", we_cnt - b, 32'd0);
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
      send_entry(32'hDEADBEEF, 32'h01234567);
      wait_idle();
      check("err_then_load_pulses", we_cnt - b, 32'd1);
      check("err_then_load_addr", {25'd0, instructionAddress}, 32'h10);
      check("err_then_load_dat", data, 32'h01234567);
      check("err_sticky", {31'd0, error}, 32'd1);

      // Reset after 5 payload bytes
      b = we_cnt;
      send_byte(8'hA5); send_byte(8'h20); send_byte(8'h02);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_values("midrst");
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("midrst_no_write", we_cnt - b, 32'd0);
      send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01);
      send_entry(32'hCAFEF00D, 32'h0BADC0DE);
      wait_idle();
      check("fresh_pulses", we_cnt - b, 32'd1);
      check("fresh_addr", {25'd0, dataAddress}, 32'd5);
      check("fresh_ins", instruction, 32'hCAFEF00D);
      check("fresh_dat", data, 32'h0BADC0DE);
      check("fresh_words", {24'd0, words_loaded}, 32'd1);
      check("final_viol", viol, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
